// File: rtl/add_chk_pkg.sv
// Shared types and default sizes for the adder result checker.
package add_chk_pkg;

  localparam int ADD_CHK_WIDTH = 16;
  localparam int ADD_CHK_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } chk_state_t;

endpackage

// File: rtl/add_result_checker_if.sv
// Operand/result bus from the adder under check to the checker.
interface add_result_checker_if
  import add_chk_pkg::*;
#(
  parameter int WIDTH = ADD_CHK_WIDTH
) ();

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;

  modport master (output in_valid, a, b, sum);
  modport slave  (input  in_valid, a, b, sum);

endinterface

// File: rtl/add_chk_pipe.sv
// Two-stage recompute/compare pipe: S1 registers the triple and the reference sum,
// S2 registers the compare result alongside the triple.
module add_chk_pipe
  import add_chk_pkg::*;
#(
  parameter int WIDTH = ADD_CHK_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   sum,
  output logic             s1_valid,
  output logic             cmp_valid,
  output logic             cmp_fail,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  output logic [WIDTH:0]   cmp_sum
);

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH:0]   s1_sum;
  logic [WIDTH:0]   s1_exp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_sum    <= '0;
      s1_exp    <= '0;
      cmp_valid <= 1'b0;
      cmp_fail  <= 1'b0;
      cmp_a     <= '0;
      cmp_b     <= '0;
      cmp_sum   <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_a      <= a;
      s1_b      <= b;
      s1_sum    <= sum;
      // Carry kept in the reference so a dropped carry-out is caught.
      s1_exp    <= {1'b0, a} + {1'b0, b};
      cmp_valid <= s1_valid;
      cmp_fail  <= s1_valid && (s1_sum != s1_exp);
      cmp_a     <= s1_a;
      cmp_b     <= s1_b;
      cmp_sum   <= s1_sum;
    end
  end

endmodule

// File: rtl/add_result_checker.sv
// Self-check stage for the adder: run FSM, vector/error counters and first-failure capture.
// Build option ADD_CHK_HALT_ON_FAIL_EN: the first mismatch ends the run early.
//
// state    | meaning
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | accepting vectors until num_vecs have been taken
// ST_DRAIN | no more input; letting S1/S2 empty
// ST_DONE  | results held until the next start
module add_result_checker
  import add_chk_pkg::*;
#(
  parameter int WIDTH = ADD_CHK_WIDTH,
  parameter int CNT_W = ADD_CHK_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_vecs,
  add_result_checker_if.slave   bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_W-1:0]      vec_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  fail_valid,
  output logic [WIDTH-1:0]      fail_a,
  output logic [WIDTH-1:0]      fail_b,
  output logic [WIDTH:0]        fail_sum
);

  chk_state_t       state;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] in_cnt_nxt;
  logic [CNT_W-1:0] num_q;
  logic             accept;
  logic             halt;
  logic             s1_valid;
  logic             cmp_valid;
  logic             cmp_fail;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic [WIDTH:0]   cmp_sum;

`ifdef ADD_CHK_HALT_ON_FAIL_EN
  assign halt = cmp_valid && cmp_fail;
`else
  assign halt = 1'b0;
`endif

  always_comb begin
    accept     = bus.in_valid && (state == ST_RUN) && (in_cnt < num_q) && !halt;
    in_cnt_nxt = in_cnt + {{(CNT_W-1){1'b0}}, accept};
  end

  add_chk_pipe #(.WIDTH(WIDTH)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .a         (bus.a),
    .b         (bus.b),
    .sum       (bus.sum),
    .s1_valid  (s1_valid),
    .cmp_valid (cmp_valid),
    .cmp_fail  (cmp_fail),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_sum   (cmp_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      in_cnt     <= '0;
      num_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      vec_cnt    <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_sum   <= '0;
    end else if (start && (state == ST_IDLE || state == ST_DONE)) begin
      state      <= ST_RUN;
      in_cnt     <= '0;
      num_q      <= num_vecs;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      vec_cnt    <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_sum   <= '0;
    end else begin
      in_cnt <= in_cnt_nxt;
      if (cmp_valid) begin
        vec_cnt <= vec_cnt + 1'b1;
        if (cmp_fail) begin
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          if (!fail_valid) begin
            fail_valid <= 1'b1;
            fail_a     <= cmp_a;
            fail_b     <= cmp_b;
            fail_sum   <= cmp_sum;
          end
        end
      end
      case (state)
        ST_RUN: begin
          if (halt || in_cnt_nxt >= num_q) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Counters are final once S2 has emptied, so pass can be taken from err_cnt.
          if (!s1_valid && !cmp_valid) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_result_checker.sv
// Scoreboard bench for add_result_checker; the halt-on-fail scenario is built only with
// ADD_CHK_HALT_ON_FAIL_EN defined.
module tb_add_result_checker;
  import add_chk_pkg::*;

  localparam int W = 16;
  localparam int C = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   s;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [C-1:0] num_vecs = '0;
  logic         busy, done, pass, fail_valid;
  logic [C-1:0] vec_cnt, err_cnt;
  logic [W-1:0] fail_a, fail_b;
  logic [W:0]   fail_sum;

  add_result_checker_if #(.WIDTH(W)) bus ();

  add_result_checker #(.WIDTH(W), .CNT_W(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_vecs   (num_vecs),
    .bus        (bus.slave),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .vec_cnt    (vec_cnt),
    .err_cnt    (err_cnt),
    .fail_valid (fail_valid),
    .fail_a     (fail_a),
    .fail_b     (fail_b),
    .fail_sum   (fail_sum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and reference model of counters/capture
  vec_t         sb[$];
  int           m_err;
  logic         m_fv;
  logic [W-1:0] m_fa, m_fb;
  logic [W:0]   m_fs;
  logic [C-1:0] prev_cnt = '0;

  task automatic model_clear();
    sb.delete();
    m_err = 0;
    m_fv  = 1'b0;
    m_fa  = '0;
    m_fb  = '0;
    m_fs  = '0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_cnt = '0;
    end else begin
      if (32'(vec_cnt) == 32'(prev_cnt) + 1) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(vec_cnt), 32'(prev_cnt));
        end else begin
          vec_t  v;
          logic [W:0] ref_sum;
          v = sb.pop_front();
          ref_sum = 17'(v.a) + 17'(v.b);
          if (v.s != ref_sum) begin
            m_err++;
            if (!m_fv) begin
              m_fv = 1'b1;
              m_fa = v.a;
              m_fb = v.b;
              m_fs = v.s;
            end
          end
          chk("err_cnt", 32'(err_cnt), 32'(m_err));
          chk("fail_valid", 32'(fail_valid), 32'(m_fv));
          chk("fail_triple", {fail_a[7:0], fail_b[7:0], 7'd0, fail_sum},
              {m_fa[7:0], m_fb[7:0], 7'd0, m_fs});
        end
      end else if (vec_cnt != prev_cnt && vec_cnt != '0) begin
        chk("vec_step", 32'(vec_cnt), 32'(prev_cnt) + 1);
      end
      prev_cnt = vec_cnt;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] s,
                      input bit acc);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.sum      = s;
    if (acc) sb.push_back('{a, b, s});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [C-1:0] n);
    model_clear();
    start    = 1'b1;
    num_vecs = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (!done && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_flags"}, {28'd0, busy, done, pass, fail_valid}, 32'd0);
    chk({tag, "_cnts"}, {vec_cnt, err_cnt}, 32'd0);
    chk({tag, "_fail"}, {fail_a, fail_b}, 32'd0);
    chk({tag, "_fsum"}, 32'(fail_sum), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.sum      = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;

    // in_valid while IDLE must be dropped
    send(16'h1, 16'h1, 17'h2, 1'b0);
    send(16'h2, 16'h2, 17'h4, 1'b0);
    @(negedge clk);
    chk("idle_vec", 32'(vec_cnt), 32'd0);

    // 1: all-good run including carry-out vectors
    do_start(16'd4);
    chk("t1_busy", 32'(busy), 32'd1);
    send(16'h0000, 16'h0000, 17'h00000, 1'b1);
    send(16'h0001, 16'h0001, 17'h00002, 1'b1);
    send(16'hFFFF, 16'h0001, 17'h10000, 1'b1);
    send(16'hFFFF, 16'hFFFF, 17'h1FFFE, 1'b1);
    wait_done(20);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_vec", 32'(vec_cnt), 32'd4);
    chk("t1_err", 32'(err_cnt), 32'd0);
    chk("t1_sb_left", 32'(sb.size()), 32'd0);

    // 2: two mismatches, the first one captured
    do_start(16'd3);
    send(16'h2, 16'h3, 17'h5, 1'b1);
    send(16'h10, 16'h20, 17'h31, 1'b1);
    send(16'h7, 16'h7, 17'hF, 1'b1);
    wait_done(20);
    chk("t2_err", 32'(err_cnt), 32'd2);
    chk("t2_fail_a", 32'(fail_a), 32'h10);
    chk("t2_fail_b", 32'(fail_b), 32'h20);
    chk("t2_fail_sum", 32'(fail_sum), 32'h31);
    chk("t2_pass", 32'(pass), 32'd0);
    chk("t2_done", 32'(done), 32'd1);

    // in_valid while DONE must be dropped and results held
    send(16'h1, 16'h1, 17'h3, 1'b0);
    @(negedge clk);
    chk("done_hold_vec", 32'(vec_cnt), 32'd3);
    chk("done_hold_err", 32'(err_cnt), 32'd2);

    // 3: empty run
    do_start(16'd0);
    wait_done(3);
    chk("t3_pass", 32'(pass), 32'd1);
    send(16'h5, 16'h5, 17'hA, 1'b0);
    send(16'h6, 16'h6, 17'hC, 1'b0);
    @(negedge clk);
    chk("t3_vec", 32'(vec_cnt), 32'd0);

    // 4: extras beyond num_vecs dropped, start during DRAIN ignored
    do_start(16'd2);
    send(16'h1, 16'h2, 17'h3, 1'b1);
    send(16'h4, 16'h5, 17'h9, 1'b1);
    start    = 1'b1;
    num_vecs = 16'd7;
    send(16'h6, 16'h6, 17'hC, 1'b0);
    start = 1'b0;
    chk("t4_drain_busy", 32'(busy), 32'd1);
    send(16'h8, 16'h8, 17'h10, 1'b0);
    send(16'h9, 16'h9, 17'h12, 1'b0);
    wait_done(20);
    chk("t4_vec", 32'(vec_cnt), 32'd2);
    chk("t4_pass", 32'(pass), 32'd1);
    chk("t4_sb_left", 32'(sb.size()), 32'd0);

    // 5: asynchronous reset in the middle of a run
    do_start(16'd3);
    send(16'h3, 16'h4, 17'h7, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_pre_vec", 32'(vec_cnt), 32'd1);
    rst = 1'b1;
    #1;
    chk_zero_outputs("t5_rst");
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_start(16'd1);
    send(16'h8, 16'h9, 17'h11, 1'b1);
    wait_done(20);
    chk("t5_pass", 32'(pass), 32'd1);
    chk("t5_vec", 32'(vec_cnt), 32'd1);

`ifdef ADD_CHK_HALT_ON_FAIL_EN
    // 6: first mismatch stops the run early
    do_start(16'd5);
    send(16'h1, 16'h1, 17'h2, 1'b1);
    send(16'h2, 16'h2, 17'h5, 1'b1);
    send(16'h3, 16'h3, 17'h6, 1'b1);
    send(16'h4, 16'h4, 17'h8, 1'b0);
    send(16'h5, 16'h5, 17'hA, 1'b0);
    wait_done(20);
    chk("t6_vec_le3", 32'(vec_cnt <= 16'd3), 32'd1);
    chk("t6_err_ge1", 32'(err_cnt >= 16'd1), 32'd1);
    chk("t6_pass", 32'(pass), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
